// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding and BCD digit limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 5;

  localparam logic [DIGIT_W-1:0] MAX_NINE = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_FIVE = 4'd5;

  // Digit order: tenths, sec_ones, sec_tens, min_ones, min_tens.
  function automatic logic [DIGIT_W-1:0] digit_max(input int idx);
    return (idx == 2 || idx == 4) ? MAX_FIVE : MAX_NINE;
  endfunction

  function automatic logic is_counting(input state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD digit of the stopwatch count; wraps at MAX and reports carry combinationally.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = MAX_NINE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  logic [DIGIT_W-1:0] q_reg;

  assign carry = inc && (q_reg == MAX);
  assign q     = q_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (inc) begin
      q_reg <= carry ? '0 : q_reg + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/lap/clear FSM, tick prescaler, 5-digit BCD count
// (mm:ss.t) and a registered display that freezes while a lap is shown.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       strtstop,
  input  logic       lap_clr,
  output logic [3:0] tenths,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_active,
  output logic       rollover
);

  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  state_t state_reg, state_next;

  logic               count_en;
  logic               enter_clear;
  logic               disp_hold;
  logic               running_next;
  logic               lap_active_next;
  logic               tick;
  logic [PRESC_W-1:0] presc_reg;
  logic               running_reg;
  logic               lap_active_reg;
  logic               rollover_reg;

  logic [NUM_DIGITS-1:0] digit_inc;
  logic [NUM_DIGITS-1:0] digit_carry;
  logic [DIGIT_W-1:0]    count_q  [NUM_DIGITS];
  logic [DIGIT_W-1:0]    disp_reg [NUM_DIGITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= CLEAR;
    end else begin
      state_reg <= state_next;
    end
  end

  // strtstop is tested first in every state so a simultaneous lap_clr is dropped.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLEAR: if (strtstop) state_next = RUN;
      RUN: begin
        if (strtstop)     state_next = PAUSE;
        else if (lap_clr) state_next = LAP;
      end
      LAP: begin
        if (strtstop)     state_next = PAUSE;
        else if (lap_clr) state_next = RUN;
      end
      PAUSE: begin
        if (strtstop)     state_next = RUN;
        else if (lap_clr) state_next = CLEAR;
      end
      default: state_next = CLEAR;
    endcase
  end

  // The display loads on the edge entering LAP (capture) and on the edge leaving it.
  always_comb begin
    count_en        = is_counting(state_reg);
    enter_clear     = (state_next == CLEAR) && (state_reg != CLEAR);
    disp_hold       = (state_reg == LAP) && (state_next == LAP);
    running_next    = is_counting(state_next);
    lap_active_next = (state_next == LAP);
  end

  assign tick = count_en && (presc_reg == PRESC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg <= '0;
    end else if (enter_clear) begin
      presc_reg <= '0;
    end else if (count_en) begin
      presc_reg <= tick ? '0 : presc_reg + PRESC_W'(1);
    end
  end

  assign digit_inc[0] = tick;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit #(
        .MAX(digit_max(gi))
      ) u_digit (
        .clk  (clk),
        .reset(reset),
        .clr  (enter_clear),
        .inc  (digit_inc[gi]),
        .q    (count_q[gi]),
        .carry(digit_carry[gi])
      );

      if (gi < NUM_DIGITS - 1) begin : g_chain
        assign digit_inc[gi+1] = digit_carry[gi];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          disp_reg[gi] <= '0;
        end else if (!disp_hold) begin
          disp_reg[gi] <= count_q[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running_reg    <= 1'b0;
      lap_active_reg <= 1'b0;
      rollover_reg   <= 1'b0;
    end else begin
      running_reg    <= running_next;
      lap_active_reg <= lap_active_next;
      rollover_reg   <= digit_carry[NUM_DIGITS-1];
    end
  end

  assign tenths     = disp_reg[0];
  assign sec_ones   = disp_reg[1];
  assign sec_tens   = disp_reg[2];
  assign min_ones   = disp_reg[3];
  assign min_tens   = disp_reg[4];
  assign running    = running_reg;
  assign lap_active = lap_active_reg;
  assign rollover   = rollover_reg;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: TICK_DIV, 5000000, clk cycles per 0.1 s tick (50 MHz -> 10 Hz); legal range >= 2.
REQ-002 Port: clk  in  1  single system clock, all logic rising-edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: strtstop  in  1  one-cycle pulse from the upstream debounce stage; start/stop command.
REQ-005 Port: lap_clr  in  1  one-cycle pulse from a second debounce instance; lap when counting, clear when paused.
REQ-006 Port: tenths  out  4  BCD 0-9, displayed tenths of seconds.
REQ-007 Port: sec_ones  out  4  BCD 0-9, displayed seconds units.
REQ-008 Port: sec_tens  out  4  BCD 0-5, displayed seconds tens.
REQ-009 Port: min_ones  out  4  BCD 0-9, displayed minutes units.
REQ-010 Port: min_tens  out  4  BCD 0-5, displayed minutes tens.
REQ-011 Port: running  out  1  high in states RUN and LAP.
REQ-012 Port: lap_active  out  1  high in state LAP (display frozen).
REQ-013 Port: rollover  out  1  one-cycle pulse when the count wraps 59:59.9 -> 00:00.0.

Function
REQ-014 The FSM SHALL have exactly four states: CLEAR, RUN, LAP, PAUSE.
REQ-015 CLEAR: strtstop -> RUN; lap_clr ignored.
REQ-016 RUN: strtstop -> PAUSE; lap_clr -> LAP and capture current count into the display register.
REQ-017 LAP: lap_clr -> RUN (display returns to live); strtstop -> PAUSE (display returns to live).
REQ-018 PAUSE: strtstop -> RUN; lap_clr -> CLEAR.
REQ-019 Simultaneous strtstop and lap_clr: strtstop takes priority; lap_clr is discarded.
REQ-020 Prescaler SHALL count 0..TICK_DIV-1 only in RUN and LAP, wrap to 0, and assert internal tick in the cycle it equals TICK_DIV-1.
REQ-021 Prescaler SHALL hold its value in PAUSE and be zeroed on entry to CLEAR.
REQ-022 On tick, the 5-digit BCD count SHALL increment by 0.1 s with carries tenths(9)->sec_ones(9)->sec_tens(5)->min_ones(9)->min_tens(5).
REQ-023 At 59:59.9 a tick SHALL produce 00:00.0 and assert rollover for exactly that update cycle; counting continues.
REQ-024 Count SHALL be zeroed on the edge that enters CLEAR; it SHALL hold in PAUSE.
REQ-025 Display outputs SHALL be registered; outside LAP they load the count every cycle (one-cycle lag behind count); in LAP they hold the captured value.
REQ-026 Count SHALL keep advancing in LAP; no tick is lost on any state transition between RUN and LAP.
REQ-027 running and lap_active SHALL be registered decodes of the state.

Reset
REQ-028 reset high SHALL immediately, without a clock edge, force state CLEAR, prescaler 0, count 0, all outputs 0.
REQ-029 reset asserted mid-operation in any state SHALL discard the count; no pulse input during reset is remembered.

Structure
REQ-030 Shared package stopwatch_pkg SHALL hold the state encoding, BCD digit width (4), and digit limits (9, 5).
REQ-031 One sub-module bcd_digit (parameter MAX; inputs clk, reset, clr, inc; outputs q[3:0], carry) SHALL be instantiated five times.

Verification (bench uses TICK_DIV=4)
REQ-032 reset, strtstop pulse, 40 cycles in RUN -> display 00:01.0, running=1, lap_active=0.
REQ-033 At 00:01.0 in RUN, lap_clr -> display holds 00:01.0 for 20 cycles; lap_clr again -> display 00:01.5 within 1 cycle, lap_active 1->0.
REQ-034 In RUN, strtstop -> display constant for 20 cycles, running=0; lap_clr -> 00:00.0, state CLEAR; next strtstop restarts with full 4-cycle first tick.
REQ-035 Run 36000 ticks from 00:00.0 -> display 00:00.0 again, rollover high exactly one cycle, at the 59:59.9 -> 00:00.0 update.
REQ-036 strtstop and lap_clr in same cycle while RUN -> PAUSE, lap_active stays 0, count not cleared.
REQ-037 reset asserted between clock edges during RUN at 00:03.7 -> all outputs 0 before the next edge; after release, remains CLEAR until strtstop.
